instr_fetch: RTL and testbench
==============================

INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h01000000, SHALL set the first fetch address after reset.
REQ-002 Parameter IM_BASE, default 32'h01000000, SHALL set the lowest legal instruction address.
REQ-003 Parameter NO_REG, default 1024, SHALL set the instruction memory depth in 32-bit words.
REQ-004 Port clk, input, 1: single clock; all state updates on its rising edge.
REQ-005 Port rst, input, 1: reset, asynchronous and active-high.
REQ-006 Port instr_Raddr, output, 32: fetch address to instruction memory.
REQ-007 Port instr_REn, output, 1: read enable to instruction memory.
REQ-008 Port I_valid, output, 1: one-cycle request strobe to instruction memory.
REQ-009 Ports instr_WEn, output, 1; W_instr, output, 32; I_clr, output, 1: all tied to 0.
REQ-010 Port R_instr, input, 32: instruction returned by memory.
REQ-011 Port I_err, input, 1: memory error flag, qualified with R_instr.
REQ-012 Ports redirect_valid, input, 1; redirect_pc, input, 32: branch/jump redirect from execute.
REQ-013 Ports instr_valid, output, 1; instr, output, 32; instr_pc, output, 32: decode-side output.
REQ-014 Port decode_ready, input, 1: decode accepts instr when instr_valid and decode_ready are both 1.
REQ-015 Ports fault, output, 1; fault_cause, output, 2; fault_pc, output, 32: fetch fault report.

Function
REQ-016 Memory protocol: a request issued in cycle N (I_valid=instr_REn=1, instr_Raddr=pc) SHALL have R_instr/I_err sampled in cycle N+1; at most one request outstanding.
REQ-017 States SHALL be RUN and FAULT; RUN issues fetches, FAULT issues none.
REQ-018 In RUN, a request SHALL issue when (buffer count + outstanding) < 2 and no redirect is present that cycle; pc increments by 4 on issue.
REQ-019 Returned instructions SHALL enter a 2-entry in-order buffer tagged with their request address; the head drives instr/instr_pc; instr_valid = buffer non-empty.
REQ-020 A sustained decode_ready=1 stream SHALL reach 1 instruction per cycle after a 2-cycle startup.
REQ-021 Before issue, pc outside [IM_BASE, IM_BASE+NO_REG*4) SHALL enter FAULT with fault_cause=2'b10, fault_pc=pc, with no memory request.
REQ-022 pc[1:0] != 0 (from redirect) SHALL enter FAULT with fault_cause=2'b01, fault_pc=pc.
REQ-023 A response with I_err=1 SHALL be discarded and SHALL enter FAULT with fault_cause=2'b11, fault_pc=its request address; buffered older entries remain deliverable.
REQ-024 redirect_valid=1 SHALL flush the buffer, drop any in-flight response, load pc=redirect_pc, and resume issuing next cycle; it SHALL also leave FAULT (clearing fault) in the same edge.
REQ-025 Simultaneous redirect and I_err/response: redirect SHALL win; response and error ignored.
REQ-026 Simultaneous buffer push and pop SHALL keep count unchanged; buffer SHALL never overflow or drop an accepted instruction.
REQ-027 Address wrap: pc+4 past IM_BASE+NO_REG*4-4 SHALL fault by REQ-021, never wrap to IM_BASE.

Reset
REQ-028 On rst: pc=RESET_PC, state=RUN, buffer empty, outstanding=0, instr_valid=0, instr=0, instr_pc=0, I_valid=0, instr_REn=0, instr_Raddr=0, fault=0, fault_cause=0, fault_pc=0.
REQ-029 Reset asserted mid-request SHALL discard the in-flight response; first request issues the first cycle after rst deasserts.

Structure
REQ-030 Package fetch_pkg SHALL hold IM_BASE, NO_REG defaults, the state enum and the fault_cause encoding.
REQ-031 The 2-entry buffer SHALL be a sub-module fetch_fifo (data+pc, push/pop, count).

Verification
REQ-032 Reset then decode_ready=1: requests at 0x01000000, 0x01000004, ...; instr_pc follows same sequence, one per cycle after startup.
REQ-033 decode_ready=0 for 5 cycles: exactly 2 instructions buffered, no further I_valid; on release they emerge in order with no loss.
REQ-034 redirect_pc=0x01000100 while response pending: buffer flushed, pending instruction never shown, next instr_pc=0x01000100.
REQ-035 I_err=1 on request at 0x01000008: fault=1, fault_cause=2'b11, fault_pc=0x01000008, I_valid stays 0 until redirect.
REQ-036 redirect_pc=0x01000FFC: one fetch at 0x01000FFC, then fault_cause=2'b10, fault_pc=0x01001000; redirect_pc=0x01000002 gives fault_cause=2'b01.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction fetch unit.
package fetch_pkg;

    localparam logic [31:0] RESET_PC_DEF = 32'h0100_0000;
    localparam logic [31:0] IM_BASE_DEF  = 32'h0100_0000;
    localparam int          NO_REG_DEF   = 1024;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FAULT = 1'b1
    } fetch_state_e;

    typedef enum logic [1:0] {
        CAUSE_NONE     = 2'b00,
        CAUSE_MISALIGN = 2'b01,
        CAUSE_RANGE    = 2'b10,
        CAUSE_BUS      = 2'b11
    } fault_cause_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] data;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Two-entry in-order buffer of fetched instructions tagged with their address.
module fetch_fifo
    import fetch_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         push,
    input  fetch_entry_t push_entry,
    input  logic         pop,
    output fetch_entry_t head,
    output logic [1:0]   count
);

    fetch_entry_t mem [2];
    logic         wr_ptr;
    logic         rd_ptr;
    logic         do_push;
    logic         do_pop;

    // A push into a full buffer is only legal when the head leaves the same cycle.
    assign do_pop  = pop && (count != 2'd0);
    assign do_push = push && ((count != 2'd2) || do_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else if (flush) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_entry;
                wr_ptr      <= ~wr_ptr;
            end
            if (do_pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + 2'(do_push) - 2'(do_pop);
        end
    end

    assign head = (count != 2'd0) ? mem[rd_ptr] : '0;

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch: one-deep memory pipeline feeding a 2-entry decode buffer,
// with redirect handling and misalign/range/bus fault reporting.
module instr_fetch
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEF,
    parameter logic [31:0] IM_BASE  = IM_BASE_DEF,
    parameter int          NO_REG   = NO_REG_DEF
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] instr_Raddr,
    output logic        instr_REn,
    output logic        I_valid,
    output logic        instr_WEn,
    output logic [31:0] W_instr,
    output logic        I_clr,
    input  logic [31:0] R_instr,
    input  logic        I_err,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    input  logic        decode_ready,
    output logic        fault,
    output logic [1:0]  fault_cause,
    output logic [31:0] fault_pc
);

    localparam logic [32:0] IM_LO = {1'b0, IM_BASE};
    localparam logic [32:0] IM_HI = {1'b0, IM_BASE} + 33'(NO_REG) * 33'd4;

    fetch_state_e state;
    fault_cause_e cause;
    logic [31:0]  pc;
    logic [31:0]  req_pc;
    logic         outstanding;
    logic [1:0]   count;
    fetch_entry_t head;
    fetch_entry_t resp_entry;
    logic [2:0]   used;
    logic         resp_ok;
    logic         resp_err;
    logic         pop;
    logic         slot_free;
    logic         want;
    logic         misalign;
    logic         out_range;
    logic         issue;

    // A response is present in the cycle after its request; redirect discards it.
    assign resp_ok  = outstanding && !redirect_valid && !I_err;
    assign resp_err = outstanding && !redirect_valid && I_err;
    assign pop      = instr_valid && decode_ready;

    // Occupancy after this cycle's pop, so a draining buffer sustains 1/cycle.
    assign used      = {1'b0, count} + {2'b00, outstanding} - {2'b00, pop};
    assign slot_free = used < 3'd2;

    assign want      = !rst && (state == ST_RUN) && !redirect_valid && !resp_err && slot_free;
    assign misalign  = pc[1:0] != 2'b00;
    assign out_range = ({1'b0, pc} < IM_LO) || ({1'b0, pc} >= IM_HI);
    assign issue     = want && !misalign && !out_range;

    assign I_valid     = issue;
    assign instr_REn   = issue;
    assign instr_Raddr = issue ? pc : '0;
    assign instr_WEn   = 1'b0;
    assign W_instr     = '0;
    assign I_clr       = 1'b0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_RUN;
            cause       <= CAUSE_NONE;
            pc          <= RESET_PC;
            req_pc      <= '0;
            outstanding <= 1'b0;
            fault_pc    <= '0;
        end else if (redirect_valid) begin
            state       <= ST_RUN;
            cause       <= CAUSE_NONE;
            pc          <= redirect_pc;
            outstanding <= 1'b0;
            fault_pc    <= '0;
        end else begin
            outstanding <= issue;
            if (issue) begin
                req_pc <= pc;
                pc     <= pc + 32'd4;
            end
            if (resp_err) begin
                state    <= ST_FAULT;
                cause    <= CAUSE_BUS;
                fault_pc <= req_pc;
            end else if (want && misalign) begin
                state    <= ST_FAULT;
                cause    <= CAUSE_MISALIGN;
                fault_pc <= pc;
            end else if (want && out_range) begin
                state    <= ST_FAULT;
                cause    <= CAUSE_RANGE;
                fault_pc <= pc;
            end
        end
    end

    assign resp_entry = '{pc: req_pc, data: R_instr};

    fetch_fifo u_fifo (
        .clk        (clk),
        .rst        (rst),
        .flush      (redirect_valid),
        .push       (resp_ok),
        .push_entry (resp_entry),
        .pop        (pop),
        .head       (head),
        .count      (count)
    );

    assign instr_valid = count != 2'd0;
    assign instr       = head.data;
    assign instr_pc    = head.pc;
    assign fault       = state == ST_FAULT;
    assign fault_cause = cause;

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: synchronous memory model plus an address-sequence reference.
module tb_instr_fetch;

    localparam logic [31:0] RESET_PC = 32'h0100_0000;
    localparam logic [31:0] IM_BASE  = 32'h0100_0000;
    localparam int          NO_REG   = 1024;
    localparam logic [31:0] IM_END   = IM_BASE + 32'(NO_REG * 4);

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] instr_Raddr;
    logic        instr_REn;
    logic        I_valid;
    logic        instr_WEn;
    logic [31:0] W_instr;
    logic        I_clr;
    logic [31:0] R_instr = '0;
    logic        I_err = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        decode_ready = 1'b0;
    logic        fault;
    logic [1:0]  fault_cause;
    logic [31:0] fault_pc;

    int          n_cmp = 0;
    int          n_fail = 0;
    logic [31:0] m_req = RESET_PC;
    logic [31:0] m_acc = RESET_PC;
    logic [31:0] err_addr = '0;
    logic        pend_v = 1'b0;
    logic [31:0] pend_a = '0;

    instr_fetch #(.RESET_PC(RESET_PC), .IM_BASE(IM_BASE), .NO_REG(NO_REG)) dut (
        .clk            (clk),
        .rst            (rst),
        .instr_Raddr    (instr_Raddr),
        .instr_REn      (instr_REn),
        .I_valid        (I_valid),
        .instr_WEn      (instr_WEn),
        .W_instr        (W_instr),
        .I_clr          (I_clr),
        .R_instr        (R_instr),
        .I_err          (I_err),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .instr_valid    (instr_valid),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .decode_ready   (decode_ready),
        .fault          (fault),
        .fault_cause    (fault_cause),
        .fault_pc       (fault_pc)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mdata(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_5A5A;
    endfunction

    // Memory: a request seen in cycle N answers throughout cycle N+1; idle cycles carry junk.
    always @(negedge clk) begin
        pend_v = I_valid;
        pend_a = instr_Raddr;
    end
    always @(posedge clk) begin
        #1;
        R_instr = pend_v ? mdata(pend_a) : $urandom;
        I_err   = pend_v && (pend_a == err_addr);
    end

    task automatic do_reset(input logic rdy);
        rst = 1'b1;
        redirect_valid = 1'b0;
        decode_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        decode_ready = rdy;
        m_req = RESET_PC;
        m_acc = RESET_PC;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        @(negedge clk);
        n_cmp++;
        if ({I_valid, instr_REn, instr_Raddr, instr_valid, instr, instr_pc} !== '0) begin
            n_fail++;
            $display("FAIL reset_fetch: got %b %b %h %b %h %h, expected all zero",
                     I_valid, instr_REn, instr_Raddr, instr_valid, instr, instr_pc);
        end
        n_cmp++;
        if ({fault, fault_cause, fault_pc, instr_WEn, W_instr, I_clr} !== '0) begin
            n_fail++;
            $display("FAIL reset_fault: got %b %b %h %b %h %b, expected all zero",
                     fault, fault_cause, fault_pc, instr_WEn, W_instr, I_clr);
        end
    endtask

    task automatic test_stream();
        do_reset(1'b1);
        for (int c = 0; c < 24; c++) begin
            @(negedge clk);
            n_cmp++;
            if (I_valid !== 1'b1 || instr_REn !== 1'b1 || instr_Raddr !== m_req) begin
                n_fail++;
                $display("FAIL stream_req c=%0d: got v=%b a=%h, expected v=1 a=%h", c, I_valid, instr_Raddr, m_req);
            end
            m_req += 4;
            n_cmp++;
            if (instr_valid !== (c >= 2) || (c >= 2 && (instr_pc !== m_acc || instr !== mdata(m_acc)))) begin
                n_fail++;
                $display("FAIL stream_out c=%0d: got v=%b pc=%h i=%h, expected v=%b pc=%h i=%h",
                         c, instr_valid, instr_pc, instr, c >= 2, m_acc, mdata(m_acc));
            end
            if (instr_valid && decode_ready) m_acc += 4;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_stall();
        logic exp_iv;
        do_reset(1'b1);
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            exp_iv = !(c >= 4 && c <= 8);
            n_cmp++;
            if (I_valid !== exp_iv || (exp_iv && instr_Raddr !== m_req)) begin
                n_fail++;
                $display("FAIL stall_req c=%0d: got v=%b a=%h, expected v=%b a=%h", c, I_valid, instr_Raddr, exp_iv, m_req);
            end
            if (I_valid) m_req += 4;
            n_cmp++;
            if (instr_valid !== (c >= 2) || (c >= 2 && (instr_pc !== m_acc || instr !== mdata(m_acc)))) begin
                n_fail++;
                $display("FAIL stall_out c=%0d: got v=%b pc=%h, expected v=%b pc=%h", c, instr_valid, instr_pc, c >= 2, m_acc);
            end
            if (c == 8) begin
                n_cmp++;
                if (m_req - m_acc !== 32'd8) begin
                    n_fail++;
                    $display("FAIL stall_depth: got %0d buffered, expected 2", (m_req - m_acc) / 4);
                end
            end
            if (instr_valid && decode_ready) m_acc += 4;
            @(posedge clk); #1;
            decode_ready = !((c + 1) >= 4 && (c + 1) <= 8);
        end
    endtask

    task automatic test_redirect();
        logic exp_iv, exp_v;
        do_reset(1'b1);
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            exp_iv = (c != 5);
            exp_v  = (c >= 2) && (c != 6) && (c != 7);
            n_cmp++;
            if (I_valid !== exp_iv || (exp_iv && instr_Raddr !== m_req)) begin
                n_fail++;
                $display("FAIL redir_req c=%0d: got v=%b a=%h, expected v=%b a=%h", c, I_valid, instr_Raddr, exp_iv, m_req);
            end
            if (I_valid) m_req += 4;
            n_cmp++;
            if (instr_valid !== exp_v || (exp_v && (instr_pc !== m_acc || instr !== mdata(m_acc)))) begin
                n_fail++;
                $display("FAIL redir_out c=%0d: got v=%b pc=%h, expected v=%b pc=%h", c, instr_valid, instr_pc, exp_v, m_acc);
            end
            if (c == 8) begin
                n_cmp++;
                if (instr_pc !== 32'h0100_0100) begin
                    n_fail++;
                    $display("FAIL redir_target: got %h, expected 01000100", instr_pc);
                end
            end
            if (instr_valid && decode_ready) m_acc += 4;
            if (c == 5) begin
                m_req = 32'h0100_0100;
                m_acc = 32'h0100_0100;
            end
            @(posedge clk); #1;
            redirect_valid = (c + 1 == 5);
            redirect_pc = 32'h0100_0100;
        end
    endtask

    task automatic test_bus_error();
        logic exp_iv, exp_v, exp_f;
        err_addr = 32'h0100_0008;
        do_reset(1'b1);
        for (int c = 0; c < 15; c++) begin
            @(negedge clk);
            exp_iv = (c <= 2) || (c >= 11);
            exp_v  = (c == 2) || (c == 3) || (c >= 13);
            exp_f  = (c >= 4) && (c <= 10);
            n_cmp++;
            if (I_valid !== exp_iv || (exp_iv && instr_Raddr !== m_req)) begin
                n_fail++;
                $display("FAIL berr_req c=%0d: got v=%b a=%h, expected v=%b a=%h", c, I_valid, instr_Raddr, exp_iv, m_req);
            end
            if (I_valid) m_req += 4;
            n_cmp++;
            if (instr_valid !== exp_v || (exp_v && (instr_pc !== m_acc || instr !== mdata(m_acc)))) begin
                n_fail++;
                $display("FAIL berr_out c=%0d: got v=%b pc=%h, expected v=%b pc=%h", c, instr_valid, instr_pc, exp_v, m_acc);
            end
            n_cmp++;
            if (fault !== exp_f) begin
                n_fail++;
                $display("FAIL berr_fault c=%0d: got %b, expected %b", c, fault, exp_f);
            end
            if (c == 4) begin
                n_cmp++;
                if ({fault_cause, fault_pc} !== {2'b11, 32'h0100_0008}) begin
                    n_fail++;
                    $display("FAIL berr_cause: got %b/%h, expected 11/01000008", fault_cause, fault_pc);
                end
            end
            if (c == 11) begin
                n_cmp++;
                if ({fault_cause, fault_pc} !== '0) begin
                    n_fail++;
                    $display("FAIL berr_clear: got %b/%h, expected 00/00000000", fault_cause, fault_pc);
                end
            end
            if (instr_valid && decode_ready) m_acc += 4;
            if (c == 10) begin
                m_req = 32'h0100_0040;
                m_acc = 32'h0100_0040;
            end
            @(posedge clk); #1;
            redirect_valid = (c + 1 == 10);
            redirect_pc = 32'h0100_0040;
        end
        err_addr = '0;
    endtask

    task automatic test_reset_midflight();
        do_reset(1'b1);
        repeat (4) begin
            @(posedge clk); #1;
        end
        @(negedge clk);
        #1 rst = 1'b1;
        #2;
        n_cmp++;
        if ({I_valid, instr_Raddr, instr_valid, instr_pc, fault} !== '0) begin
            n_fail++;
            $display("FAIL midreset_zero: got v=%b a=%h iv=%b pc=%h f=%b, expected all zero",
                     I_valid, instr_Raddr, instr_valid, instr_pc, fault);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        m_req = RESET_PC;
        m_acc = RESET_PC;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            n_cmp++;
            if (I_valid !== 1'b1 || instr_Raddr !== m_req) begin
                n_fail++;
                $display("FAIL midreset_req c=%0d: got v=%b a=%h, expected v=1 a=%h", c, I_valid, instr_Raddr, m_req);
            end
            m_req += 4;
            n_cmp++;
            if (instr_valid !== (c >= 2) || (c >= 2 && (instr_pc !== m_acc || instr !== mdata(m_acc)))) begin
                n_fail++;
                $display("FAIL midreset_out c=%0d: got v=%b pc=%h, expected v=%b pc=%h", c, instr_valid, instr_pc, c >= 2, m_acc);
            end
            if (instr_valid && decode_ready) m_acc += 4;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_range_misalign();
        logic exp_iv, exp_v, exp_f;
        do_reset(1'b1);
        for (int c = 0; c < 17; c++) begin
            @(negedge clk);
            exp_iv = (c <= 2) || (c == 4);
            exp_v  = (c == 2) || (c == 3) || (c == 6);
            exp_f  = (c >= 6 && c <= 9) || (c >= 11 && c <= 13) || (c >= 15);
            n_cmp++;
            if (I_valid !== exp_iv || (exp_iv && instr_Raddr !== m_req)) begin
                n_fail++;
                $display("FAIL range_req c=%0d: got v=%b a=%h, expected v=%b a=%h", c, I_valid, instr_Raddr, exp_iv, m_req);
            end
            if (I_valid) m_req += 4;
            n_cmp++;
            if (instr_valid !== exp_v || (exp_v && (instr_pc !== m_acc || instr !== mdata(m_acc)))) begin
                n_fail++;
                $display("FAIL range_out c=%0d: got v=%b pc=%h, expected v=%b pc=%h", c, instr_valid, instr_pc, exp_v, m_acc);
            end
            n_cmp++;
            if (fault !== exp_f) begin
                n_fail++;
                $display("FAIL range_fault c=%0d: got %b, expected %b", c, fault, exp_f);
            end
            if (c == 6 || c == 11 || c == 15) begin
                n_cmp++;
                if ((c == 6  && {fault_cause, fault_pc} !== {2'b10, 32'h0100_1000}) ||
                    (c == 11 && {fault_cause, fault_pc} !== {2'b01, 32'h0100_0002}) ||
                    (c == 15 && {fault_cause, fault_pc} !== {2'b10, 32'h00FF_FFF0})) begin
                    n_fail++;
                    $display("FAIL range_cause c=%0d: got %b/%h", c, fault_cause, fault_pc);
                end
            end
            if (instr_valid && decode_ready) m_acc += 4;
            if (c == 3) begin
                m_req = 32'h0100_0FFC;
                m_acc = 32'h0100_0FFC;
            end
            @(posedge clk); #1;
            redirect_valid = (c + 1 == 3) || (c + 1 == 9) || (c + 1 == 13);
            redirect_pc = (c + 1 == 3) ? 32'h0100_0FFC : (c + 1 == 9) ? 32'h0100_0002 : 32'h00FF_FFF0;
        end
    endtask

    task automatic test_random();
        int nreq = 0;
        int nacc = 0;
        do_reset(1'b1);
        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            if (I_valid) begin
                n_cmp++;
                if (instr_Raddr !== m_req || instr_Raddr >= IM_END || instr_Raddr < IM_BASE || redirect_valid) begin
                    n_fail++;
                    $display("FAIL rand_req c=%0d: got a=%h rv=%b, expected a=%h rv=0", c, instr_Raddr, redirect_valid, m_req);
                end
                m_req += 4;
            end
            if (instr_valid && decode_ready) begin
                n_cmp++;
                if (instr_pc !== m_acc || instr !== mdata(m_acc)) begin
                    n_fail++;
                    $display("FAIL rand_out c=%0d: got pc=%h i=%h, expected pc=%h i=%h", c, instr_pc, instr, m_acc, mdata(m_acc));
                end
                m_acc += 4;
            end
            if (redirect_valid) begin
                m_req = redirect_pc;
                m_acc = redirect_pc;
            end
            @(posedge clk); #1;
            decode_ready = ($urandom_range(0, 3) != 0);
            if (!redirect_valid && $urandom_range(0, 15) == 0) begin
                redirect_valid = 1'b1;
                redirect_pc = IM_BASE + 32'(4 * $urandom_range(0, NO_REG - 1));
            end else begin
                redirect_valid = 1'b0;
            end
        end
        // Final segment runs into the top of memory so the stream ends deterministically.
        redirect_valid = 1'b1;
        redirect_pc = IM_END - 32'd16;
        decode_ready = 1'b1;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (I_valid) begin
                n_cmp++;
                if (instr_Raddr !== m_req) begin
                    n_fail++;
                    $display("FAIL drain_req c=%0d: got %h, expected %h", c, instr_Raddr, m_req);
                end
                m_req += 4;
                nreq++;
            end
            if (instr_valid && decode_ready) begin
                n_cmp++;
                if (instr_pc !== m_acc || instr !== mdata(m_acc)) begin
                    n_fail++;
                    $display("FAIL drain_out c=%0d: got %h, expected %h", c, instr_pc, m_acc);
                end
                m_acc += 4;
                if (c > 0) nacc++;
            end
            if (redirect_valid) begin
                m_req = redirect_pc;
                m_acc = redirect_pc;
            end
            @(posedge clk); #1;
            redirect_valid = 1'b0;
        end
        n_cmp++;
        if (nreq != 4 || nacc != 4) begin
            n_fail++;
            $display("FAIL drain_count: got req=%0d acc=%0d, expected 4/4", nreq, nacc);
        end
        n_cmp++;
        if ({fault, fault_cause, fault_pc} !== {1'b1, 2'b10, IM_END}) begin
            n_fail++;
            $display("FAIL drain_fault: got %b %b %h, expected 1 10 %h", fault, fault_cause, fault_pc, IM_END);
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_redirect();
        test_bus_error();
        test_reset_midflight();
        test_range_misalign();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
